// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the nibble-serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    localparam int NIBBLE = 4;

    // Width of the nibble index counter; never narrower than one bit
    function automatic int nsa_idx_width(input int n_steps);
        return (n_steps > 1) ? $clog2(n_steps) : 1;
    endfunction

endpackage

// File: rtl/fulladder_4bit.sv
// rtl/fulladder_4bit.sv - combinational 4-bit ripple-carry adder slice
module fulladder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] w_c;

    // Ripple the carry through four single-bit full adders
    always_comb begin
        w_c    = '0;
        Sum    = '0;
        w_c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
        end
    end

    assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder reusing one 4-bit slice, one nibble per clock
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N    = WIDTH / NIBBLE;
    localparam int IDXW = nsa_idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    nsa_state_t       r_state;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic [IDXW-1:0]  r_idx;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_fa_sum;
    logic             w_fa_cout;

    assign w_a_nib = r_a_q[NIBBLE*r_idx +: NIBBLE];
    assign w_b_nib = r_b_q[NIBBLE*r_idx +: NIBBLE];

    fulladder_4bit u_fa (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_carry_q),
        .Sum  (w_fa_sum),
        .Cout (w_fa_cout)
    );

    // Control FSM plus operand, partial-sum and carry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_q     <= a;
                        r_b_q     <= b;
                        r_carry_q <= cin;
                        r_idx     <= '0;
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    r_sum_q[NIBBLE*r_idx +: NIBBLE] <= w_fa_sum;
                    r_carry_q                       <= w_fa_cout;
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the state register only, so no input reaches them combinationally
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum_q;
    assign cout      = r_carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder at WIDTH 16, 4 and 32
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        iv16, ir16, cin16, ov16, bz16, co16;
    logic        or16;
    logic [15:0] a16, b16, s16;

    logic        iv4, ir4, cin4, ov4, bz4, co4;
    logic        or4 = 1'b1;
    logic [3:0]  a4, b4, s4;

    logic        iv32, ir32, cin32, ov32, bz32, co32;
    logic        or32 = 1'b1;
    logic [31:0] a32, b32, s32;

    bit rnd4_en  = 1'b0;
    bit rnd32_en = 1'b0;

    logic [32:0] q16[$];
    logic [32:0] q4[$];
    logic [32:0] q32[$];

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
        .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .busy(bz32)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Random consumer backpressure for the stream DUTs
    always @(posedge clk) begin
        #1;
        or4  = rnd4_en  ? 1'($urandom_range(0, 1)) : 1'b1;
        or32 = rnd32_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitors: pop and compare on each completed output handshake
    always @(negedge clk) begin
        if (rst_n && ov16 && or16) begin
            n_cmp++;
            assert (q16.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result16 observed=%h expected=none", {co16, s16});
            end
            if (q16.size() != 0) check("result16", 33'({co16, s16}), q16.pop_front());
        end
        if (rst_n && ov4 && or4) begin
            n_cmp++;
            assert (q4.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result4 observed=%h expected=none", {co4, s4});
            end
            if (q4.size() != 0) check("result4", 33'({co4, s4}), q4.pop_front());
        end
        if (rst_n && ov32 && or32) begin
            n_cmp++;
            assert (q32.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_result32 observed=%h expected=none", {co32, s32});
            end
            if (q32.size() != 0) check("result32", 33'({co32, s32}), q32.pop_front());
        end
    end

    task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic c);
        iv16  = 1'b1;
        a16   = a;
        b16   = b;
        cin16 = c;
        check("in_ready_before_accept16", 33'(ir16), 33'(1));
        q16.push_back(33'({1'b0, a} + {1'b0, b} + {16'd0, c}));
        tick;
        iv16 = 1'b0;
    endtask

    task automatic wait_ov16(output int n);
        n = 0;
        while (!ov16 && n < 40) begin
            tick;
            n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc;
        int prev;

        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; or16 = 1'b1;
        iv4  = 0; a4  = 0; b4  = 0; cin4  = 0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0;
        repeat (3) tick;

        // Reset state
        check("rst_in_ready", 33'(ir16), 33'(1));
        check("rst_out_valid", 33'(ov16), 33'(0));
        check("rst_busy", 33'(bz16), 33'(0));
        check("rst_sum_cout", 33'({co16, s16}), 33'(0));
        rst_n = 1'b1;
        tick;

        // Basic add: latency 4, DONE lasts one cycle
        accept16(16'h1234, 16'h4321, 1'b0);
        check("busy_in_calc", 33'(bz16), 33'(1));
        wait_ov16(n);
        check("latency_basic", 33'(n), 33'(4));
        tick;
        check("done_one_cycle", 33'(ov16), 33'(0));
        check("idle_after_done", 33'(ir16), 33'(1));

        // Full carry ripple
        accept16(16'hFFFF, 16'h0001, 1'b0);
        wait_ov16(n);
        check("latency_ripple1", 33'(n), 33'(4));
        tick;
        accept16(16'hFFFF, 16'hFFFF, 1'b1);
        wait_ov16(n);
        check("latency_ripple2", 33'(n), 33'(4));
        tick;

        // Backpressure: result held while out_ready is low
        or16 = 1'b0;
        accept16(16'h00F0, 16'h0010, 1'b0);
        wait_ov16(n);
        check("latency_bp", 33'(n), 33'(4));
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 33'(s16), 33'(16'h0100));
            check("bp_cout", 33'(co16), 33'(0));
            check("bp_in_ready", 33'(ir16), 33'(0));
            check("bp_out_valid", 33'(ov16), 33'(1));
            tick;
        end
        or16 = 1'b1;
        tick;
        check("bp_release_in_ready", 33'(ir16), 33'(1));
        check("bp_release_busy", 33'(bz16), 33'(0));

        // Input pulsed during CALC is ignored
        accept16(16'h0001, 16'h0002, 1'b0);
        iv16 = 1'b1;
        a16  = 16'hAAAA;
        b16  = 16'h5555;
        tick;
        iv16 = 1'b0;
        wait_ov16(n);
        check("latency_busy_input", 33'(n), 33'(3));
        tick;
        for (int i = 0; i < 6; i++) begin
            check("no_extra_result", 33'(ov16), 33'(0));
            tick;
        end

        // Reset during CALC step 2 discards the operation
        accept16(16'h1111, 16'h2222, 1'b0);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 33'(ov16), 33'(0));
        check("midrst_in_ready", 33'(ir16), 33'(1));
        check("midrst_sum_cout", 33'({co16, s16}), 33'(0));
        check("midrst_busy", 33'(bz16), 33'(0));
        q16.delete();
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("midrst_no_result", 33'(ov16), 33'(0));
            tick;
        end
        accept16(16'h8000, 16'h8000, 1'b1);
        wait_ov16(n);
        check("latency_after_rst", 33'(n), 33'(4));
        tick;
        check("q16_drained", 33'(q16.size()), 33'(0));

        // Random back-to-back stream, WIDTH=4
        rnd4_en = 1'b1;
        prev = 0;
        for (int k = 0; k < 30; k++) begin
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            cin4 = 1'($urandom);
            iv4  = 1'b1;
            n = 0;
            while (!ir4 && n < 60) begin
                tick;
                n++;
            end
            check("in_ready4_wait", 33'(ir4), 33'(1));
            acc = cyc + 1;
            if (k > 0) check("interval4", 33'(acc - prev >= 3), 33'(1));
            q4.push_back(33'({1'b0, a4} + {1'b0, b4} + {4'd0, cin4}));
            tick;
            prev = acc;
        end
        iv4 = 1'b0;
        n = 0;
        while (q4.size() != 0 && n < 200) begin
            tick;
            n++;
        end
        check("q4_drained", 33'(q4.size()), 33'(0));
        rnd4_en = 1'b0;

        // Random back-to-back stream, WIDTH=32
        rnd32_en = 1'b1;
        prev = 0;
        for (int k = 0; k < 30; k++) begin
            a32   = $urandom;
            b32   = $urandom;
            cin32 = 1'($urandom);
            iv32  = 1'b1;
            n = 0;
            while (!ir32 && n < 100) begin
                tick;
                n++;
            end
            check("in_ready32_wait", 33'(ir32), 33'(1));
            acc = cyc + 1;
            if (k > 0) check("interval32", 33'(acc - prev >= 10), 33'(1));
            q32.push_back({1'b0, a32} + {1'b0, b32} + {32'd0, cin32});
            tick;
            prev = acc;
        end
        iv32 = 1'b0;
        n = 0;
        while (q32.size() != 0 && n < 400) begin
            tick;
            n++;
        end
        check("q32_drained", 33'(q32.size()), 33'(0));
        rnd32_en = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
